// File: rtl/leb128_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | leb128_pkg : shared types and limits for the LEB128 immediate-fetch stage  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package leb128_pkg;

  typedef enum logic [1:0] {
    ERR_OK     = 2'd0,
    ERR_MEM    = 2'd1,
    ERR_RANGE  = 2'd2,
    ERR_NO_64B = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MAX_BYTES32 = 5;
  localparam int MAX_BYTES64 = 10;

endpackage
`default_nettype wire

// File: rtl/leb128_last_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | leb128_last_check : range check of the final byte an encoding may use      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module leb128_last_check
  import leb128_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_signed,
  input  logic       i_wide64,
  output logic       o_ok
);

  // Bits that would land above the target width must be zero (unsigned)
  // or a copy of the target's sign bit (signed).
  always_comb begin
    o_ok = 1'b0;
    if (!i_byte[7]) begin
      case ({i_wide64, i_signed})
        2'b00:   o_ok = (i_byte[6:4] == 3'b000);
        2'b01:   o_ok = (i_byte[6:3] == 4'b0000) || (i_byte[6:3] == 4'b1111);
        2'b10:   o_ok = (i_byte[6:1] == 6'b000000);
        default: o_ok = (i_byte[6:0] == 7'h00) || (i_byte[6:0] == 7'h7F);
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/leb128_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | leb128_fetch : byte-serial LEB128 immediate fetch/decode (u32/s32/u64/s64) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module leb128_fetch
  import leb128_pkg::*;
#(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4,
  parameter int USE_64B   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [MEM_DEPTH:0]            req_pc,
  input  logic                          req_signed,
  input  logic                          req_wide64,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_value,
  output logic [MEM_DEPTH:0]            out_next_pc,
  output logic [1:0]                    out_err
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2**MEM_EXTRA) * 8;
  localparam bit C_NO_64B = (USE_64B == 0);

  state_e          r_state, w_next;
  logic            r_signed, r_wide;
  logic [AW-1:0]   r_addr;       // address currently presented to the ROM
  logic [3:0]      r_cnt;        // bytes already accumulated
  logic [63:0]     r_acc;
  logic [63:0]     r_value;
  logic [AW-1:0]   r_next_pc;
  err_e            r_err;

  logic [7:0]      w_byte;
  logic [6:0]      w_shift, w_shift_new, w_top;
  logic [5:0]      w_pos;
  logic [63:0]     w_acc_new, w_mask, w_ext, w_result;
  logic            w_last, w_cont, w_range_ok, w_accept, w_no64;

  assign w_byte    = mem_data[7:0];
  assign mem_extra = '0;
  assign mem_addr  = r_addr;

  generate
    if (DW > 8) begin : g_unused_data
      logic w_unused_hi;
      assign w_unused_hi = ^mem_data[DW-1:8];
    end
  endgenerate

  assign w_shift     = {3'b000, r_cnt} * 7'd7;
  assign w_shift_new = w_shift + 7'd7;
  assign w_acc_new   = r_acc | ({57'd0, w_byte[6:0]} << w_shift);
  assign w_last      = (r_cnt == (r_wide ? 4'(MAX_BYTES64 - 1) : 4'(MAX_BYTES32 - 1)));
  assign w_cont      = w_byte[7] && !w_last;

  // Sign bit is the top decoded bit, clamped to the target width: on a
  // range-checked final byte the clamped bit equals the true sign.
  assign w_top  = r_wide ? 7'd63 : 7'd31;
  assign w_pos  = ((w_shift_new - 7'd1) > w_top) ? w_top[5:0] : 6'(w_shift_new - 7'd1);
  assign w_mask = (64'd2 << w_pos) - 64'd1;
  assign w_ext  = w_acc_new[w_pos] ? (w_acc_new | ~w_mask) : (w_acc_new & w_mask);

  always_comb begin
    w_result = 64'd0;
    if (r_signed) w_result = r_wide ? w_ext : {32'd0, w_ext[31:0]};
    else          w_result = r_wide ? w_acc_new : {32'd0, w_acc_new[31:0]};
  end

  leb128_last_check u_last_check (
    .i_byte   (w_byte),
    .i_signed (r_signed),
    .i_wide64 (r_wide),
    .o_ok     (w_range_ok)
  );

  assign w_no64   = req_wide64 && C_NO_64B;
  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_no64 ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: w_next = ST_DATA;
      ST_DATA: begin
        if (mem_error || !w_cont) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_signed  <= 1'b0;
      r_wide    <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= 4'd0;
      r_acc     <= 64'd0;
      r_value   <= 64'd0;
      r_next_pc <= '0;
      r_err     <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_signed <= req_signed;
            r_wide   <= req_wide64;
            r_acc    <= 64'd0;
            r_cnt    <= 4'd0;
            if (w_no64) begin
              r_value   <= 64'd0;
              r_next_pc <= req_pc;
              r_err     <= ERR_NO_64B;
            end else begin
              r_addr <= req_pc;
            end
          end
        end
        ST_FETCH: r_addr <= r_addr + 1'b1;
        ST_DATA: begin
          if (mem_error) begin
            r_value   <= 64'd0;
            r_next_pc <= r_addr - 1'b1;
            r_err     <= ERR_MEM;
          end else if (w_cont) begin
            r_acc  <= w_acc_new;
            r_cnt  <= r_cnt + 4'd1;
            r_addr <= r_addr + 1'b1;
          end else begin
            r_next_pc <= r_addr;
            if (w_last && !w_range_ok) begin
              r_value <= 64'd0;
              r_err   <= ERR_RANGE;
            end else begin
              r_value <= w_result;
              r_err   <= ERR_OK;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_value   = r_value;
  assign out_next_pc = r_next_pc;
  assign out_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_leb128_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_leb128_fetch : directed + random checks against an arithmetic LEB model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_leb128_fetch;

  localparam int AW = 7;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_signed = 1'b0, req_wide64 = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] req_pc = '0;
  logic          req_ready, out_valid, mem_error;
  logic [AW-1:0] mem_addr, out_next_pc;
  logic [3:0]    mem_extra;
  logic [DW-1:0] mem_data;
  logic [63:0]   out_value;
  logic [1:0]    out_err;

  logic          req_valid0 = 1'b0, out_ready0 = 1'b0;
  logic          req_ready0, out_valid0;
  logic [AW-1:0] mem_addr0, out_next_pc0;
  logic [3:0]    mem_extra0;
  logic [63:0]   out_value0;
  logic [1:0]    out_err0;
  logic [DW-1:0] mem_data0 = '0;

  leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_signed(req_signed), .req_wide64(req_wide64),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data),
    .mem_error(mem_error), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_next_pc(out_next_pc), .out_err(out_err)
  );

  leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_pc(7'd9), .req_signed(1'b0), .req_wide64(1'b1),
    .mem_addr(mem_addr0), .mem_extra(mem_extra0), .mem_data(mem_data0),
    .mem_error(1'b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_value(out_value0), .out_next_pc(out_next_pc0), .out_err(out_err0)
  );

  // ROM with one cycle read latency and an upper-bound error flag
  logic [7:0] rom [128];
  int         ub = 127;
  always @(posedge clk) begin
    mem_data  <= {120'd0, rom[mem_addr]};
    mem_error <= (int'(mem_addr) > ub);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Reference: accumulate the whole encoding as a wide integer, then test
  // whether that number fits the target type.
  task automatic model(input logic [AW-1:0] pc, input bit sgn, input bit wide,
                       output logic [63:0] v, output logic [AW-1:0] npc,
                       output logic [1:0] err, output int nb);
    logic [127:0]        acc;
    logic signed [127:0] sval, lim;
    logic [AW-1:0]       a;
    logic [7:0]          b;
    int                  maxb, width, n;
    bit                  ok;
    maxb = wide ? 10 : 5;
    width = wide ? 64 : 32;
    acc = '0;
    n = 0;
    for (int i = 0; i < maxb; i++) begin
      a = AW'(int'(pc) + i);
      if (int'(a) > ub) begin
        v = 64'd0; npc = a; err = 2'd1; nb = i + 1;
        return;
      end
      b = rom[a];
      acc = acc | (128'(b[6:0]) << (7 * i));
      if (!b[7]) begin
        n = i + 1;
        break;
      end
      if (i == maxb - 1) begin
        v = 64'd0; npc = AW'(int'(a) + 1); err = 2'd2; nb = i + 1;
        return;
      end
    end
    sval = $signed(acc);
    if (sgn && acc[7*n-1]) sval = $signed(acc) - $signed(128'd1 << (7 * n));
    lim = $signed(128'd1 << (width - 1));
    if (sgn) ok = (sval >= -lim) && (sval < lim);
    else     ok = (acc < (128'd1 << width));
    npc = AW'(int'(pc) + n);
    nb = n;
    if (!ok) begin
      v = 64'd0; err = 2'd2;
    end else begin
      v = wide ? sval[63:0] : {32'd0, sval[31:0]};
      err = 2'd0;
    end
  endtask

  task automatic run(input logic [AW-1:0] pc, input bit sgn, input bit wide, input string tag);
    logic [63:0]   ev;
    logic [AW-1:0] enpc;
    logic [1:0]    eerr;
    int            enb, cyc, d;
    model(pc, sgn, wide, ev, enpc, eerr, enb);
    req_pc = pc; req_signed = sgn; req_wide64 = wide; req_valid = 1'b1;
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    check({tag, "_lat"}, 64'(cyc), 64'(enb + 1));
    check({tag, "_val"}, out_value, ev);
    check({tag, "_npc"}, 64'(out_next_pc), 64'(enpc));
    check({tag, "_err"}, 64'(out_err), 64'(eerr));
    d = $urandom_range(0, 2);
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1 check({tag, "_hold"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic put(input int base, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    rom[AW'(base)]     = b0; rom[AW'(base + 1)] = b1; rom[AW'(base + 2)] = b2;
    rom[AW'(base + 3)] = b3; rom[AW'(base + 4)] = b4;
  endtask

  initial begin
    logic [7:0] edges [10];
    bit         seen;
    int         pc, len;
    logic [7:0] b;
    edges = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h07, 8'h08, 8'h78, 8'h7F, 8'h7E, 8'h40};
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_value", out_value, 64'd0);
    check("rst_npc",   64'(out_next_pc), 64'd0);
    check("rst_err",   64'(out_err), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Wide request on the 32-bit-only build finishes at once with no ROM access
    req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    check("no64_valid", 64'(out_valid0), 64'd1);
    check("no64_err",   64'(out_err0), 64'd3);
    check("no64_value", out_value0, 64'd0);
    check("no64_addr",  64'(mem_addr0), 64'd0);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    check("no64_ready", 64'(req_ready0), 64'd1);

    rom[0] = 8'h07;
    run(7'd0, 1'b0, 1'b1, "u64_07");
    check("u64_07_abs", out_value, 64'd7);
    put(10, 8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00);
    run(7'd10, 1'b0, 1'b0, "u32_3b");
    check("u32_3b_abs", out_value, 64'd624485);
    rom[20] = 8'h7F;
    run(7'd20, 1'b1, 1'b1, "s64_7f");
    check("s64_7f_abs", out_value, 64'hFFFF_FFFF_FFFF_FFFF);
    run(7'd20, 1'b1, 1'b0, "s32_7f");
    check("s32_7f_abs", out_value, 64'h0000_0000_FFFF_FFFF);
    put(30, 8'h80, 8'h80, 8'h80, 8'h80, 8'h78);
    run(7'd30, 1'b1, 1'b0, "s32_min");
    check("s32_min_abs", out_value, 64'h0000_0000_8000_0000);
    put(40, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10);
    run(7'd40, 1'b0, 1'b0, "u32_ovf");
    check("u32_ovf_abs", 64'(out_err), 64'd2);
    put(50, 8'h80, 8'h80, 8'h80, 8'h01, 8'h00);
    ub = 52;
    run(7'd50, 1'b0, 1'b1, "u64_bound");
    check("u64_bound_abs", 64'(out_next_pc), 64'd53);
    ub = 127;

    // Reset pulse while the u32 decode is in DATA discards it
    req_pc = 7'd10; req_signed = 1'b0; req_wide64 = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_ready", 64'(req_ready), 64'd1);
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_value", out_value, 64'd0);
    check("mid_npc",   64'(out_next_pc), 64'd0);
    check("mid_addr",  64'(mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_noout", 64'(seen), 64'd0);
    run(7'd10, 1'b0, 1'b0, "mid_rerun");

    for (int it = 0; it < 60; it++) begin
      pc = $urandom_range(0, 127);
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom) & 8'h7F;
        if (i == len - 1 && $urandom_range(0, 1) == 1) b = edges[$urandom_range(0, 9)];
        if (i < len - 1) b = b | 8'h80;
        rom[AW'(pc + i)] = b;
      end
      ub = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : 127;
      run(AW'(pc), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
